ddr4_reset_n_ctrl: RTL
======================

# ddr4_reset_n_ctrl

Fabric-side sequencer for the DDR4 RESET_N pad lane. It generates the JEDEC power-up reset sequence on the 4:1 serialized TX_DATA_0/OE_DATA_0 bus: RESET_N held low, then released, then a wait before CKE may rise. It also steps the lane's dynamic output delay line through its MOVE/DIRECTION/LOAD controls and tracks the tap position. It sits between the DDR4 PHY training/init controller and the RESET_N IOD wrapper, in the FAB_CLK domain.

## Interface
Parameters:
- RESET_HOLD_CYC, 33334: FAB_CLK cycles RESET_N is held low (200 us at 166.67 MHz).
- CKE_WAIT_CYC, 83334: FAB_CLK cycles after RESET_N release before reset_done (500 us).
- CNT_W, 17: width of the sequence counter; must hold max(RESET_HOLD_CYC, CKE_WAIT_CYC).
- TAP_W, 8: width of tap_cnt.
- TAP_MAX, 127: highest legal tap index.

Ports:
- FAB_CLK  in  1  fabric clock; all logic is rising-edge.
- ARST_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins or restarts the reset sequence.
- TX_DATA_0  out  4  RESET_N serialized data, 4 bits per FAB_CLK.
- OE_DATA_0  out  4  pad output enable, 4 bits per FAB_CLK.
- reset_done  out  1  high once the CKE wait has elapsed.
- busy  out  1  high in ASSERT or STAB.
- dly_req  in  1  single-cycle delay-step request.
- dly_dir  in  1  step direction, sampled with dly_req: 1 = increment, 0 = decrement.
- dly_ack  out  1  one-cycle completion pulse.
- dly_err  out  1  valid with dly_ack; 1 = step refused.
- tap_cnt  out  TAP_W  current tap index.
- DELAY_LINE_MOVE_0  out  1  delay line move strobe.
- DELAY_LINE_DIRECTION_0  out  1  delay line direction.
- DELAY_LINE_LOAD_0  out  1  delay line load strobe.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  delay line range flag from the IOD.

## Operation
Reset values:
- TX_DATA_0 = 4'h0 (RESET_N low) and OE_DATA_0 = 4'hF, so the pad drives low from reset.
- All other outputs = 0; tap_cnt = 0.

Sequence FSM (states IDLE, ASSERT, STAB, DONE):
- IDLE: TX_DATA_0 = 4'h0. start → ASSERT.
- ASSERT: TX_DATA_0 = 4'h0; counter counts up to RESET_HOLD_CYC, then → STAB with the counter cleared.
- STAB: TX_DATA_0 = 4'hF; counter counts up to CKE_WAIT_CYC, then → DONE.
- DONE: TX_DATA_0 = 4'hF; reset_done = 1.
- start while in ASSERT is ignored.
- start while in STAB or DONE restarts ASSERT: counter cleared, reset_done = 0 and TX_DATA_0 = 4'h0 on the next cycle.
- OE_DATA_0 is 4'hF in every state.

Delay FSM (states DL_LOAD, DL_IDLE, DL_MOVE, DL_WAIT):
- After ARST_N deasserts, DL_LOAD pulses DELAY_LINE_LOAD_0 for 1 cycle, clears tap_cnt, then → DL_IDLE.
- In DL_IDLE, dly_req is accepted. The step is refused if any of these hold: tap_cnt == TAP_MAX with dly_dir = 1; tap_cnt == 0 with dly_dir = 0; DELAY_LINE_OUT_OF_RANGE_0 = 1.
- Refused step: dly_ack = 1 and dly_err = 1 on the next cycle; no MOVE pulse; tap_cnt unchanged.
- Accepted step → DL_MOVE: DELAY_LINE_DIRECTION_0 = dly_dir and DELAY_LINE_MOVE_0 = 1 for 1 cycle. DIRECTION is held until the next request.
- DL_WAIT lasts 2 cycles. Then tap_cnt updates ±1, dly_ack = 1 and dly_err = 0, and the FSM returns to DL_IDLE.
- dly_req outside DL_IDLE is dropped with no ack.
- The delay FSM is independent of the sequence FSM; both may be active in the same cycle.

## Timing
- start at cycle N: state is ASSERT at N+1. TX_DATA_0 becomes 4'hF at N+1+RESET_HOLD_CYC.
- reset_done rises at N+1+RESET_HOLD_CYC+CKE_WAIT_CYC.
- Accepted dly_req at cycle M: MOVE high at M+1, ack at M+4; the next request can be accepted at M+5.
- Refused dly_req at cycle M: ack/err at M+1.
- ARST_N asserted mid-operation: all outputs return to their reset values immediately and asynchronously.

## Configuration
- RESET_N_CTRL_AUTOSTART_EN defined: IDLE → ASSERT on the first cycle after ARST_N deasserts; start still restarts the sequence as above.
- Undefined: the FSM waits in IDLE for start.

## Structure
- Package ddr4_phy_ctrl_pkg holds:
  - the sequence and delay state enums;
  - the TX_DATA_0 constants RST_LOW = 4'h0 and RST_HIGH = 4'hF;
  - the default timing constants.
- Sub-module ddr4_dly_line_stepper contains the delay FSM, tap_cnt and the range check.

## Test plan
All scenarios use RESET_HOLD_CYC = 10, CKE_WAIT_CYC = 20, TAP_MAX = 3.
- Reset release, start at cycle 5 → TX_DATA_0 = 4'h0 through cycle 15; 4'hF from cycle 16; reset_done = 1 at cycle 36; OE_DATA_0 = 4'hF throughout.
- start at cycle 20 of the run above (during STAB) → TX_DATA_0 = 4'h0 at cycle 21; reset_done stays 0; TX_DATA_0 = 4'hF again at cycle 31.
- Four increment requests from tap 0 → three MOVE pulses with DIRECTION = 1 and tap_cnt = 3; the fourth is acked with dly_err = 1 and no MOVE.
- DELAY_LINE_OUT_OF_RANGE_0 = 1 with a decrement request at tap 2 → dly_ack with dly_err = 1; tap_cnt stays 2.
- dly_req at the MOVE cycle of an in-progress step → dropped; exactly one ack.
- ARST_N pulsed during STAB → TX_DATA_0 = 4'h0, tap_cnt = 0, reset_done = 0; after release, one LOAD pulse follows.

Source files
------------

// File: rtl/ddr4_phy_ctrl_pkg.sv
`timescale 1ns/1ps
// ddr4_phy_ctrl_pkg
// Shared types and constants for the DDR4 RESET_N lane controller:
//   seq_state_t  - power-up reset sequence states
//   dly_state_t  - output delay line stepper states
//   RST_LOW/HIGH - TX_DATA_0 patterns for RESET_N driven low/high
//   DEF_*        - default timing and width constants (166.67 MHz FAB_CLK)
package ddr4_phy_ctrl_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_ASSERT = 2'd1,
        SEQ_STAB   = 2'd2,
        SEQ_DONE   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        DL_LOAD = 2'd0,
        DL_IDLE = 2'd1,
        DL_MOVE = 2'd2,
        DL_WAIT = 2'd3
    } dly_state_t;

    localparam logic [3:0] RST_LOW  = 4'h0;
    localparam logic [3:0] RST_HIGH = 4'hF;

    localparam int DEF_RESET_HOLD_CYC = 33334;
    localparam int DEF_CKE_WAIT_CYC   = 83334;
    localparam int DEF_CNT_W          = 17;
    localparam int DEF_TAP_W          = 8;
    localparam int DEF_TAP_MAX        = 127;

endpackage

// File: rtl/ddr4_dly_line_stepper.sv
`timescale 1ns/1ps
// ddr4_dly_line_stepper
// Steps the RESET_N lane output delay line one tap at a time and tracks the
// tap position. Loads the line once after reset, then serves single-step
// requests, refusing any step that would leave [0, TAP_MAX] or that arrives
// while the IOD reports out-of-range.
//
// Ports:
//   FAB_CLK, ARST_N             clock, async active-low reset
//   dly_req, dly_dir            step request pulse and direction (1 = inc)
//   dly_ack, dly_err            completion pulse, refusal flag
//   tap_cnt                     current tap index
//   DELAY_LINE_MOVE_0           move strobe to the IOD
//   DELAY_LINE_DIRECTION_0      direction to the IOD, held between requests
//   DELAY_LINE_LOAD_0           load strobe to the IOD
//   DELAY_LINE_OUT_OF_RANGE_0   range flag from the IOD
//
// state   | meaning
// DL_LOAD | first cycle out of reset: pulse LOAD, clear tap_cnt
// DL_IDLE | waiting for dly_req
// DL_MOVE | MOVE strobe on the pad
// DL_WAIT | two settle cycles, then tap update and ack
module ddr4_dly_line_stepper
    import ddr4_phy_ctrl_pkg::*;
#(
    parameter int TAP_W   = DEF_TAP_W,
    parameter int TAP_MAX = DEF_TAP_MAX
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             dly_req,
    input  logic             dly_dir,
    output logic             dly_ack,
    output logic             dly_err,
    output logic [TAP_W-1:0] tap_cnt,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

    localparam logic [TAP_W-1:0] TAP_TOP = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);

    dly_state_t       r_state, w_state;
    logic             r_wait, w_wait;
    logic [TAP_W-1:0] r_tap, w_tap;
    logic             r_ack, w_ack;
    logic             r_err, w_err;
    logic             r_move, w_move;
    logic             r_dir, w_dir;
    logic             r_load, w_load;
    logic             w_refuse;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state <= DL_LOAD;
            r_wait  <= 1'b0;
            r_tap   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_move  <= 1'b0;
            r_dir   <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_wait  <= w_wait;
            r_tap   <= w_tap;
            r_ack   <= w_ack;
            r_err   <= w_err;
            r_move  <= w_move;
            r_dir   <= w_dir;
            r_load  <= w_load;
        end
    end

    assign w_refuse = DELAY_LINE_OUT_OF_RANGE_0
                    | ( dly_dir && (r_tap == TAP_TOP))
                    | (!dly_dir && (r_tap == '0));

    always_comb begin
        w_state = r_state;
        w_wait  = r_wait;
        w_tap   = r_tap;
        w_ack   = 1'b0;
        w_err   = 1'b0;
        w_move  = 1'b0;
        w_dir   = r_dir;
        w_load  = 1'b0;
        case (r_state)
            DL_LOAD: begin
                w_load  = 1'b1;
                w_tap   = '0;
                w_state = DL_IDLE;
            end
            DL_IDLE: begin
                // The ack cycle itself is not a request slot: the earliest
                // follow-up request is the cycle after the ack.
                if (dly_req && !r_ack) begin
                    if (w_refuse) begin
                        w_ack = 1'b1;
                        w_err = 1'b1;
                    end else begin
                        w_dir   = dly_dir;
                        w_move  = 1'b1;
                        w_state = DL_MOVE;
                    end
                end
            end
            DL_MOVE: begin
                w_wait  = 1'b0;
                w_state = DL_WAIT;
            end
            DL_WAIT: begin
                if (r_wait) begin
                    w_tap   = r_dir ? (r_tap + TAP_ONE) : (r_tap - TAP_ONE);
                    w_ack   = 1'b1;
                    w_state = DL_IDLE;
                end else begin
                    w_wait = 1'b1;
                end
            end
            default: w_state = DL_LOAD;
        endcase
    end

    assign dly_ack                = r_ack;
    assign dly_err                = r_err;
    assign tap_cnt                = r_tap;
    assign DELAY_LINE_MOVE_0      = r_move;
    assign DELAY_LINE_DIRECTION_0 = r_dir;
    assign DELAY_LINE_LOAD_0      = r_load;

endmodule

// File: rtl/ddr4_reset_n_ctrl.sv
`timescale 1ns/1ps
// ddr4_reset_n_ctrl
// DDR4 RESET_N lane sequencer: holds RESET_N low for RESET_HOLD_CYC, releases
// it, waits CKE_WAIT_CYC and raises reset_done. The pad is always driven
// (OE_DATA_0 all ones). Also hosts the delay line stepper for the lane.
// Build option: RESET_N_CTRL_AUTOSTART_EN starts the sequence right after
// reset instead of waiting for start.
//
// Ports:
//   FAB_CLK, ARST_N          clock, async active-low reset
//   start                    begin/restart the reset sequence
//   TX_DATA_0, OE_DATA_0     4:1 serialized RESET_N data and output enable
//   reset_done, busy         sequence status
//   dly_req/dly_dir/dly_ack/dly_err/tap_cnt   delay step handshake and tap
//   DELAY_LINE_*_0           delay line controls/status of the IOD
//
// state      | meaning
// SEQ_IDLE   | out of reset, RESET_N low, waiting for start
// SEQ_ASSERT | RESET_N held low for RESET_HOLD_CYC
// SEQ_STAB   | RESET_N high, waiting CKE_WAIT_CYC
// SEQ_DONE   | RESET_N high, reset_done asserted
module ddr4_reset_n_ctrl
    import ddr4_phy_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYC = DEF_RESET_HOLD_CYC,
    parameter int CKE_WAIT_CYC   = DEF_CKE_WAIT_CYC,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TAP_W          = DEF_TAP_W,
    parameter int TAP_MAX        = DEF_TAP_MAX
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             start,
    output logic [3:0]       TX_DATA_0,
    output logic [3:0]       OE_DATA_0,
    output logic             reset_done,
    output logic             busy,
    input  logic             dly_req,
    input  logic             dly_dir,
    output logic             dly_ack,
    output logic             dly_err,
    output logic [TAP_W-1:0] tap_cnt,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CKE_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    seq_state_t       r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state <= SEQ_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
        end
    end

    // Outputs decode straight from the state register so ARST_N forces the
    // pad low without waiting for a clock.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        TX_DATA_0  = RST_LOW;
        OE_DATA_0  = RST_HIGH;
        reset_done = 1'b0;
        busy       = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                w_cnt = '0;
`ifdef RESET_N_CTRL_AUTOSTART_EN
                w_state = SEQ_ASSERT;
`else
                if (start) w_state = SEQ_ASSERT;
`endif
            end
            SEQ_ASSERT: begin
                busy = 1'b1;
                if (r_cnt == HOLD_LAST) begin
                    w_cnt   = '0;
                    w_state = SEQ_STAB;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            SEQ_STAB: begin
                busy      = 1'b1;
                TX_DATA_0 = RST_HIGH;
                if (start) begin
                    w_cnt   = '0;
                    w_state = SEQ_ASSERT;
                end else if (r_cnt == WAIT_LAST) begin
                    w_cnt   = '0;
                    w_state = SEQ_DONE;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            SEQ_DONE: begin
                TX_DATA_0  = RST_HIGH;
                reset_done = 1'b1;
                if (start) begin
                    w_cnt   = '0;
                    w_state = SEQ_ASSERT;
                end
            end
            default: w_state = SEQ_IDLE;
        endcase
    end

    ddr4_dly_line_stepper #(
        .TAP_W   (TAP_W),
        .TAP_MAX (TAP_MAX)
    ) u_stepper (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .dly_req                   (dly_req),
        .dly_dir                   (dly_dir),
        .dly_ack                   (dly_ack),
        .dly_err                   (dly_err),
        .tap_cnt                   (tap_cnt),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0)
    );

endmodule
